sort4_sched: RTL and testbench
==============================

Name: sort4_sched

Overview:
- Round-robin scheduler that shares one 4-input odd-even sort unit (sort4) between NUM_REQ requesters in the softmax path.
- Accepts one 4-operand request at a time and drives the sort unit's sort_en / in1..in4.
- Tracks the unit's 6-step sequence and returns the ascending result tagged with the requester id over a valid/ready response channel.

Parameters:
- DATA_W, 16: operand width; must equal `OUTPUT_BUF_DATASIZE.
- NUM_REQ, 4: number of requesters, 2..8.
- ID_W, 2: width of resp_id; must be at least clog2(NUM_REQ).
- TIMEOUT, 15: watchdog limit in SORT cycles; used only with SORT_SCHED_TIMEOUT_EN.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_data  in  NUM_REQ*4*DATA_W  requester r operand k at [(r*4+k)*DATA_W +: DATA_W].
- req_ready  out  NUM_REQ  one-hot accept pulse.
- sort_en  out  1  to sort unit.
- sort_in  out  4*DATA_W  to sort unit in1..in4 (in1 = lowest slice).
- sort_finish  in  1  from sort unit.
- sort_out  in  4*DATA_W  from sort unit {out_large2, out_large1, out_small2, out_small1}.
- resp_valid  out  1  response valid.
- resp_ready  in  1  response ready.
- resp_id  out  ID_W  index of the served requester.
- resp_data  out  4*DATA_W  ascending; smallest in the lowest slice.
- resp_err  out  1  watchdog abort flag.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (async assert, sync release):
  - FSM goes to IDLE.
  - sort_en, req_ready, resp_valid and resp_err = 0.
  - resp_id, resp_data and the operand register = 0.
  - RR pointer = NUM_REQ-1, so requester 0 has highest priority first.
  - Reset mid-operation drops sort_en immediately. The sort unit self-clears its step counter when sort_en is low.
- IDLE:
  - If any req_valid is set, grant the first set bit scanning from pointer+1 mod NUM_REQ.
  - In the same cycle: req_ready[g] = 1 (combinational, single cycle), latch that requester's 4 operands into the operand register, store g, set pointer = g, go to SORT.
  - If no req_valid is set, stay in IDLE.
- SORT:
  - sort_en = 1; sort_in is driven from the operand register, stable for the whole state.
  - The sort unit loads operands at its step 0, and sort_finish rises on the 7th SORT cycle.
  - In the sort_finish cycle, go to CAPTURE. sort_en must be 0 in the next cycle, because holding it would restart the unit.
- CAPTURE:
  - One cycle with sort_en = 0; the sort outputs are final here.
  - Register sort_out into resp_data, the stored g into resp_id, clear resp_err, go to RESP.
- RESP:
  - resp_valid = 1; resp_data and resp_id are held stable until resp_ready = 1.
  - On the handshake, go to IDLE. No request is accepted in the RESP handshake cycle.
  - Backpressure may last indefinitely; req_ready stays 0 throughout.
- Latency:
  - resp_valid rises 9 cycles after the cycle in which req_ready pulsed.
  - Minimum 10 cycles per transaction.
- Fairness: a requester holding req_valid is served within NUM_REQ transactions.
- req_valid changes outside IDLE have no effect.
- Equal operands pass through unchanged in value, for example resp_data = 5,5,5,5.
- sort_finish outside SORT is ignored.

Optional Feature:
- Macro: SORT_SCHED_TIMEOUT_EN.
- Defined:
  - A cycle counter clears on SORT entry and counts SORT cycles.
  - If it reaches TIMEOUT with no sort_finish, drop sort_en and go directly to RESP with resp_err = 1, resp_data = 0, and resp_id = g.
  - The handshake in RESP is unchanged.
- Undefined:
  - No counter is built; resp_err is tied to 0.
  - SORT waits for sort_finish indefinitely.

Test Plan:
- Single request from req 2, operands (in1..in4) = 9,3,7,1 -> req_ready = 0100 for one cycle; resp_valid 9 cycles later; resp_id = 2; resp_data slices = 1,3,7,9; resp_err = 0.
- All four req_valid held high for 5 transactions, resp_ready = 1 -> grant order 0,1,2,3,0; each response tagged with the matching id; exactly one sort_en pulse of 7 cycles per transaction.
- Operands 4,3,2,1 then 5,5,5,5 -> results 1,2,3,4 and 5,5,5,5; sort_en low for at least 1 cycle between transactions.
- resp_ready held low for 6 cycles in RESP while req 1 is valid -> resp_valid stays 1, resp_data stable, req_ready = 0; after the handshake, req 1 is granted on the following IDLE cycle.
- rst_n pulsed low on the 3rd SORT cycle -> sort_en, busy and resp_valid drop to 0 asynchronously; after release, a fresh request 8,6,4,2 returns 2,4,6,8 normally.
- With SORT_SCHED_TIMEOUT_EN and the sort_finish stub stuck at 0 -> sort_en drops after 15 SORT cycles; resp_valid with resp_err = 1 and resp_data = 0. Without the macro, the FSM remains in SORT.

Source files
------------

// File: rtl/sort4_sched_if.sv
// Request/response bundle between requesters and the sort4 scheduler.
// master = requester side, slave = scheduler side.
interface sort4_sched_if #(
    parameter int DATA_W  = 16,
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]          req_valid;
    logic [NUM_REQ*4*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]          req_ready;
    logic                        resp_valid;
    logic                        resp_ready;
    logic [ID_W-1:0]             resp_id;
    logic [4*DATA_W-1:0]         resp_data;
    logic                        resp_err;

    modport master (
        output req_valid, req_data, resp_ready,
        input  req_ready, resp_valid, resp_id, resp_data, resp_err
    );

    modport slave (
        input  req_valid, req_data, resp_ready,
        output req_ready, resp_valid, resp_id, resp_data, resp_err
    );
endinterface

// File: rtl/sort4_sched.sv
// Round-robin scheduler sharing one 4-input sort unit between NUM_REQ requesters.
// Define SORT_SCHED_TIMEOUT_EN to build the SORT-state watchdog (TIMEOUT cycles).
module sort4_sched #(
    parameter int DATA_W  = 16,
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                rst_n,
    sort4_sched_if.slave        bus,
    output logic                sort_en,
    output logic [4*DATA_W-1:0] sort_in,
    input  logic                sort_finish,
    input  logic [4*DATA_W-1:0] sort_out,
    output logic                busy
);
    localparam int NP = 1 << ID_W;
    localparam logic [ID_W-1:0] LAST = ID_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        IDLE,
        SORT,
        CAPTURE,
        RESP
    } state_t;

    state_t state_q, state_d;

    logic [ID_W-1:0]     ptr_q;
    logic [ID_W-1:0]     gid_q;
    logic [4*DATA_W-1:0] opnd_q;
    logic [ID_W-1:0]     rid_q;
    logic [4*DATA_W-1:0] rdata_q;

    logic [NP-1:0]       vpad;
    logic [ID_W-1:0]     cand;
    logic [ID_W-1:0]     grant_id;
    logic                grant_any;
    logic [NUM_REQ-1:0]  grant_oh;
    logic [4*DATA_W-1:0] sel_ops;

    logic load;
    logic capture;
    logic abort;
    logic timeout_hit;

    assign vpad = NP'(bus.req_valid);

    // round-robin pick: first valid requester after the pointer
    always_comb begin
        grant_any = 1'b0;
        grant_id  = '0;
        cand      = ptr_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = (cand == LAST) ? '0 : cand + 1'b1;
            if (!grant_any && vpad[cand]) begin
                grant_any = 1'b1;
                grant_id  = cand;
            end
        end
    end

    // decode winner into one-hot and select its operand group
    always_comb begin
        grant_oh = '0;
        sel_ops  = '0;
        for (int r = 0; r < NUM_REQ; r++) begin
            if (grant_id == ID_W'(r)) begin
                grant_oh[r] = 1'b1;
                sel_ops = bus.req_data[r*4*DATA_W +: 4*DATA_W];
            end
        end
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // next state and per-state strobes
    always_comb begin
        state_d       = state_q;
        sort_en       = 1'b0;
        bus.req_ready = '0;
        load          = 1'b0;
        capture       = 1'b0;
        abort         = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (grant_any) begin
                    bus.req_ready = grant_oh;
                    load          = 1'b1;
                    state_d       = SORT;
                end
            end
            SORT: begin
                sort_en = 1'b1;
                if (sort_finish) begin
                    state_d = CAPTURE;
                end else if (timeout_hit) begin
                    abort   = 1'b1;
                    state_d = RESP;
                end
            end
            CAPTURE: begin
                capture = 1'b1;
                state_d = RESP;
            end
            RESP: begin
                if (bus.resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // operand latch, pointer and response registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q   <= LAST;
            gid_q   <= '0;
            opnd_q  <= '0;
            rid_q   <= '0;
            rdata_q <= '0;
        end else begin
            if (load) begin
                ptr_q  <= grant_id;
                gid_q  <= grant_id;
                opnd_q <= sel_ops;
            end
            if (capture) begin
                rdata_q <= sort_out;
                rid_q   <= gid_q;
            end else if (abort) begin
                rdata_q <= '0;
                rid_q   <= gid_q;
            end
        end
    end

`ifdef SORT_SCHED_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LIM = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q;
    logic          err_q;

    assign timeout_hit = (cnt_q == LIM);
    assign bus.resp_err = err_q;

    // count SORT cycles since entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                          cnt_q <= '0;
        else if (load)                       cnt_q <= '0;
        else if (state_q == SORT && !timeout_hit) cnt_q <= cnt_q + 1'b1;
    end

    // error flag: set on watchdog abort, cleared on normal capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       err_q <= 1'b0;
        else if (capture) err_q <= 1'b0;
        else if (abort)   err_q <= 1'b1;
    end
`else
    // no watchdog: SORT waits on sort_finish alone
    assign timeout_hit  = (TIMEOUT < 0);
    assign bus.resp_err = 1'b0;
`endif

    assign sort_in        = opnd_q;
    assign bus.resp_valid = (state_q == RESP);
    assign bus.resp_id    = rid_q;
    assign bus.resp_data  = rdata_q;
    assign busy           = (state_q != IDLE);
endmodule

// File: tb/tb_sort4_sched.sv
// Self-checking bench for sort4_sched with a behavioural sort4 stub.
// Stub loads at step 0, raises sort_finish on step 6, clears when sort_en is low.
module tb_sort4_sched;
    localparam int DW = 16;
    localparam int NR = 4;
    localparam int IW = 2;

    typedef struct {
        logic [IW-1:0]   id;
        logic [4*DW-1:0] data;
        logic            err;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic sort_en;
    logic [4*DW-1:0] sort_in;
    logic sort_finish;
    logic [4*DW-1:0] sort_out;
    logic busy;
    logic stub_stuck;

    logic [3:0]      step;
    logic [4*DW-1:0] stub_res;

    int vectors = 0;
    int miscompares = 0;
    int run = 0;
    int plens[$];
    exp_t sb[$];

    sort4_sched_if #(.DATA_W(DW), .NUM_REQ(NR), .ID_W(IW)) ifc ();

    sort4_sched #(.DATA_W(DW), .NUM_REQ(NR), .ID_W(IW), .TIMEOUT(15)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(ifc),
        .sort_en(sort_en),
        .sort_in(sort_in),
        .sort_finish(sort_finish),
        .sort_out(sort_out),
        .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [4*DW-1:0] pk(int a, int b, int c, int d);
        return {d[DW-1:0], c[DW-1:0], b[DW-1:0], a[DW-1:0]};
    endfunction

    function automatic logic [4*DW-1:0] sort4f(logic [4*DW-1:0] x);
        logic [DW-1:0] v[4];
        logic [DW-1:0] t;
        for (int i = 0; i < 4; i++) v[i] = x[i*DW +: DW];
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3 - i; j++)
                if (v[j] > v[j+1]) begin
                    t = v[j]; v[j] = v[j+1]; v[j+1] = t;
                end
        return {v[3], v[2], v[1], v[0]};
    endfunction

    // sort unit stub: result valid only from the finish step on
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step <= '0;
            stub_res <= '0;
        end else if (!sort_en) begin
            step <= '0;
        end else begin
            if (step != 4'hf) step <= step + 1'b1;
            if (step == 4'd0) stub_res <= sort4f(sort_in);
        end
    end

    assign sort_finish = sort_en && (step == 4'd6) && !stub_stuck;
    assign sort_out = (step >= 4'd6) ? stub_res : '1;

    // record length of each sort_en pulse
    always @(negedge clk) begin
        if (sort_en) run++;
        else if (run != 0) begin
            plens.push_back(run);
            run = 0;
        end
    end

    initial begin
        #300us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic set_req(int r, logic [4*DW-1:0] v);
        ifc.req_data[r*4*DW +: 4*DW] = v;
    endtask

    task automatic wait_resp(output int n);
        n = 0;
        while (!ifc.resp_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        stub_stuck = 1'b0;
        ifc.req_valid = '0;
        ifc.req_data = '0;
        ifc.resp_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_busy: got %b want 0", busy);
        end
        vectors++;
        if (sort_en !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_sort_en: got %b want 0", sort_en);
        end
        vectors++;
        if (ifc.resp_valid !== 1'b0 || ifc.resp_err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_resp: got v=%b e=%b want 0 0", ifc.resp_valid, ifc.resp_err);
        end
        vectors++;
        if (ifc.resp_id !== '0 || ifc.resp_data !== '0) begin
            miscompares++;
            $display("FAIL reset_resp_regs: got id=%0h d=%0h want 0 0", ifc.resp_id, ifc.resp_data);
        end
        vectors++;
        if (ifc.req_ready !== '0) begin
            miscompares++;
            $display("FAIL reset_req_ready: got %b want 0", ifc.req_ready);
        end
    endtask

    task automatic test_round_robin();
        int n;
        int g;
        exp_t e;
        ifc.resp_ready = 1'b1;
        for (int r = 0; r < NR; r++) set_req(r, pk(r*16+4, r*16+1, r*16+3, r*16+2));
        plens.delete();
        ifc.req_valid = 4'hf;
        for (int t = 0; t < 5; t++) begin
            g = t % NR;
            n = 0;
            #1;
            while (ifc.req_ready === '0 && n < 20) begin
                @(negedge clk);
                #1;
                n++;
            end
            vectors++;
            if (ifc.req_ready !== 4'(1 << g)) begin
                miscompares++;
                $display("FAIL rr_grant%0d: got %b want %b", t, ifc.req_ready, 4'(1 << g));
            end
            sb.push_back('{id: IW'(g), data: pk(g*16+1, g*16+2, g*16+3, g*16+4), err: 1'b0});
            @(negedge clk);
            wait_resp(n);
            e = sb.pop_front();
            vectors++;
            if (ifc.resp_valid !== 1'b1 || ifc.resp_id !== e.id) begin
                miscompares++;
                $display("FAIL rr_id%0d: got v=%b id=%0d want 1 %0d", t, ifc.resp_valid, ifc.resp_id, e.id);
            end
            vectors++;
            if (ifc.resp_data !== e.data) begin
                miscompares++;
                $display("FAIL rr_data%0d: got %h want %h", t, ifc.resp_data, e.data);
            end
            if (t == 4) ifc.req_valid = '0;
            @(negedge clk);
        end
        vectors++;
        if (plens.size() != 5) begin
            miscompares++;
            $display("FAIL rr_pulse_count: got %0d want 5", plens.size());
        end
        foreach (plens[i]) begin
            vectors++;
            if (plens[i] != 7) begin
                miscompares++;
                $display("FAIL rr_pulse_len%0d: got %0d want 7", i, plens[i]);
            end
        end
    endtask

    task automatic test_single();
        int n;
        exp_t e;
        ifc.resp_ready = 1'b1;
        set_req(2, pk(9, 3, 7, 1));
        ifc.req_valid = 4'b0100;
        #1;
        vectors++;
        if (ifc.req_ready !== 4'b0100) begin
            miscompares++;
            $display("FAIL single_grant: got %b want 0100", ifc.req_ready);
        end
        sb.push_back('{id: 2'd2, data: pk(1, 3, 7, 9), err: 1'b0});
        @(negedge clk);
        ifc.req_valid = '0;
        #1;
        vectors++;
        if (ifc.req_ready !== '0) begin
            miscompares++;
            $display("FAIL single_ready_pulse: got %b want 0000", ifc.req_ready);
        end
        wait_resp(n);
        vectors++;
        if (n + 1 != 9) begin
            miscompares++;
            $display("FAIL single_latency: got %0d want 9", n + 1);
        end
        e = sb.pop_front();
        vectors++;
        if (ifc.resp_id !== e.id || ifc.resp_err !== e.err) begin
            miscompares++;
            $display("FAIL single_id_err: got %0d %b want %0d %b", ifc.resp_id, ifc.resp_err, e.id, e.err);
        end
        vectors++;
        if (ifc.resp_data !== e.data) begin
            miscompares++;
            $display("FAIL single_data: got %h want %h", ifc.resp_data, e.data);
        end
        @(negedge clk);
    endtask

    task automatic test_equal_ops();
        logic [4*DW-1:0] ins[2];
        logic [4*DW-1:0] outs[2];
        int n;
        exp_t e;
        ins[0] = pk(4, 3, 2, 1);
        outs[0] = pk(1, 2, 3, 4);
        ins[1] = pk(5, 5, 5, 5);
        outs[1] = pk(5, 5, 5, 5);
        ifc.resp_ready = 1'b1;
        plens.delete();
        for (int k = 0; k < 2; k++) begin
            set_req(0, ins[k]);
            ifc.req_valid = 4'b0001;
            #1;
            vectors++;
            if (ifc.req_ready !== 4'b0001) begin
                miscompares++;
                $display("FAIL eq_grant%0d: got %b want 0001", k, ifc.req_ready);
            end
            sb.push_back('{id: 2'd0, data: outs[k], err: 1'b0});
            @(negedge clk);
            ifc.req_valid = '0;
            wait_resp(n);
            e = sb.pop_front();
            vectors++;
            if (ifc.resp_valid !== 1'b1 || ifc.resp_data !== e.data || ifc.resp_id !== e.id) begin
                miscompares++;
                $display("FAIL eq_data%0d: got v=%b %h id=%0d want 1 %h %0d", k, ifc.resp_valid, ifc.resp_data, ifc.resp_id, e.data, e.id);
            end
            @(negedge clk);
        end
        vectors++;
        if (plens.size() != 2) begin
            miscompares++;
            $display("FAIL eq_separate_pulses: got %0d want 2", plens.size());
        end
    endtask

    task automatic test_backpressure();
        int n;
        exp_t e;
        ifc.resp_ready = 1'b0;
        set_req(0, pk(12, 10, 11, 13));
        ifc.req_valid = 4'b0001;
        #1;
        sb.push_back('{id: 2'd0, data: pk(10, 11, 12, 13), err: 1'b0});
        @(negedge clk);
        set_req(1, pk(2, 1, 4, 3));
        ifc.req_valid = 4'b0010;
        wait_resp(n);
        e = sb.pop_front();
        for (int i = 0; i < 6; i++) begin
            #1;
            vectors++;
            if (ifc.resp_valid !== 1'b1 || ifc.resp_data !== e.data || ifc.req_ready !== '0) begin
                miscompares++;
                $display("FAIL bp_hold%0d: got v=%b d=%h rdy=%b want 1 %h 0000", i, ifc.resp_valid, ifc.resp_data, ifc.req_ready, e.data);
            end
            @(negedge clk);
        end
        ifc.resp_ready = 1'b1;
        #1;
        vectors++;
        if (ifc.resp_id !== e.id || ifc.req_ready !== '0) begin
            miscompares++;
            $display("FAIL bp_handshake: got id=%0d rdy=%b want %0d 0000", ifc.resp_id, ifc.req_ready, e.id);
        end
        @(negedge clk);
        #1;
        vectors++;
        if (ifc.req_ready !== 4'b0010) begin
            miscompares++;
            $display("FAIL bp_next_grant: got %b want 0010", ifc.req_ready);
        end
        sb.push_back('{id: 2'd1, data: pk(1, 2, 3, 4), err: 1'b0});
        @(negedge clk);
        ifc.req_valid = '0;
        wait_resp(n);
        e = sb.pop_front();
        vectors++;
        if (ifc.resp_valid !== 1'b1 || ifc.resp_id !== e.id || ifc.resp_data !== e.data) begin
            miscompares++;
            $display("FAIL bp_second: got v=%b id=%0d %h want 1 %0d %h", ifc.resp_valid, ifc.resp_id, ifc.resp_data, e.id, e.data);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_sort();
        int n;
        exp_t e;
        ifc.resp_ready = 1'b1;
        set_req(0, pk(1, 2, 3, 4));
        ifc.req_valid = 4'b0001;
        @(negedge clk);
        ifc.req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (sort_en !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_pre_sort_en: got %b want 1", sort_en);
        end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (sort_en !== 1'b0 || busy !== 1'b0 || ifc.resp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_async_drop: got en=%b busy=%b v=%b want 0 0 0", sort_en, busy, ifc.resp_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        set_req(0, pk(8, 6, 4, 2));
        ifc.req_valid = 4'b0001;
        #1;
        vectors++;
        if (ifc.req_ready !== 4'b0001) begin
            miscompares++;
            $display("FAIL rst_regrant: got %b want 0001", ifc.req_ready);
        end
        sb.push_back('{id: 2'd0, data: pk(2, 4, 6, 8), err: 1'b0});
        @(negedge clk);
        ifc.req_valid = '0;
        wait_resp(n);
        e = sb.pop_front();
        vectors++;
        if (ifc.resp_valid !== 1'b1 || ifc.resp_data !== e.data || ifc.resp_err !== e.err) begin
            miscompares++;
            $display("FAIL rst_fresh: got v=%b %h e=%b want 1 %h %b", ifc.resp_valid, ifc.resp_data, ifc.resp_err, e.data, e.err);
        end
        @(negedge clk);
    endtask

    task automatic test_stuck_finish();
        int n;
        stub_stuck = 1'b1;
        ifc.resp_ready = 1'b1;
        set_req(3, pk(7, 7, 1, 1));
        ifc.req_valid = 4'b1000;
        #1;
        vectors++;
        if (ifc.req_ready !== 4'b1000) begin
            miscompares++;
            $display("FAIL stuck_grant: got %b want 1000", ifc.req_ready);
        end
        plens.delete();
        @(negedge clk);
        ifc.req_valid = '0;
`ifdef SORT_SCHED_TIMEOUT_EN
        begin
            exp_t e;
            sb.push_back('{id: 2'd3, data: '0, err: 1'b1});
            wait_resp(n);
            e = sb.pop_front();
            vectors++;
            if (n + 1 != 16) begin
                miscompares++;
                $display("FAIL to_latency: got %0d want 16", n + 1);
            end
            vectors++;
            if (ifc.resp_err !== e.err || ifc.resp_data !== e.data || ifc.resp_id !== e.id) begin
                miscompares++;
                $display("FAIL to_resp: got e=%b %h id=%0d want %b %h %0d", ifc.resp_err, ifc.resp_data, ifc.resp_id, e.err, e.data, e.id);
            end
            @(negedge clk);
            @(negedge clk);
            vectors++;
            if (plens.size() != 1 || plens[0] != 15) begin
                miscompares++;
                $display("FAIL to_pulse: got n=%0d len=%0d want 1 15", plens.size(), (plens.size() > 0) ? plens[0] : -1);
            end
        end
`else
        repeat (40) @(negedge clk);
        vectors++;
        if (sort_en !== 1'b1 || busy !== 1'b1 || ifc.resp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL stuck_hold: got en=%b busy=%b v=%b want 1 1 0", sort_en, busy, ifc.resp_valid);
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
`endif
        stub_stuck = 1'b0;
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single();
        test_equal_ops();
        test_backpressure();
        test_reset_mid_sort();
        test_stuck_finish();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
